// File: rtl/adder_if_pkg.sv
// adder_if_pkg
//   Shared definitions for the Req/Ack byte-serial adder interface:
//   requester FSM state encoding, data width and default timing parameters.
package adder_if_pkg;

    localparam int DATA_W          = 32;
    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int LAT_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Timer width able to hold TIMEOUT_CYC plus one headroom bit.
    function automatic int timer_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1) + 1;
    endfunction

endpackage

// File: rtl/adder_req_timer.sv
// adder_req_timer
//   Transaction timer for the adder requester. Loaded with 1 when a request
//   is issued and incremented on every edge while enabled. It provides the
//   timeout compare and the saturated latency values reported with a result.
// Ports
//   Cclk      in   clock
//   Rstn      in   synchronous active-low reset (clears the count)
//   load      in   load the count with 1
//   en        in   increment the count (ignored when load is high)
//   expired   out  count == TIMEOUT_CYC
//   lat_next  out  count+1, saturated to LAT_W bits (latency on normal completion)
//   lat_tmo   out  TIMEOUT_CYC, saturated to LAT_W bits (latency on timeout)
module adder_req_timer
    import adder_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int LAT_W       = LAT_W_DEF
) (
    input  logic             Cclk,
    input  logic             Rstn,
    input  logic             load,
    input  logic             en,
    output logic             expired,
    output logic [LAT_W-1:0] lat_next,
    output logic [LAT_W-1:0] lat_tmo
);

    localparam int TW = timer_width(TIMEOUT_CYC);
    // Compare width wide enough for both the count and the latency range.
    localparam int CW = ((LAT_W > TW) ? LAT_W : TW) + 1;

    logic [TW-1:0] count;
    logic [CW-1:0] nxt_wide;
    logic [CW-1:0] lat_max_wide;
    logic [CW-1:0] tmo_wide;

    always_ff @(posedge Cclk) begin
        if (!Rstn) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(1);
        end else if (en && (count != {TW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign nxt_wide     = CW'(count) + CW'(1);
    assign lat_max_wide = CW'({LAT_W{1'b1}});
    assign tmo_wide     = CW'(TIMEOUT_CYC);

    assign expired  = (count == TW'(TIMEOUT_CYC));
    assign lat_next = (nxt_wide > lat_max_wide) ? {LAT_W{1'b1}} : nxt_wide[LAT_W-1:0];
    assign lat_tmo  = (tmo_wide > lat_max_wide) ? {LAT_W{1'b1}} : tmo_wide[LAT_W-1:0];

endmodule

// File: rtl/adder_requester.sv
// adder_requester
//   Initiator side of the Req/Ack byte-serial adder interface. Takes operand
//   pairs from the host, issues them to the adder with Req, follows Ack
//   through acceptance (Ack low) and completion (Ack high again), and returns
//   the sum, an error flag and the measured latency to the host.
//
//   Handshake rule on both host ports: a transfer happens on a rising Cclk
//   edge where valid and ready are both high. valid, once raised by the
//   sender, is held with its payload stable until that transfer.
//
// Ports
//   Cclk, Rstn          clock; synchronous active-low reset
//   op_valid/op_ready   operand port; op_a, op_b operands
//   res_valid/res_ready result port; res_sum, res_err (timeout), res_lat
//   A, B, Req           toward the adder; A/B stable from Req rise to Sum capture
//   Ack, Sum            from the adder; Ack idles high, low = busy
//   fsm_state           current FSM state (state_t encoding), for observation
module adder_requester
    import adder_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int LAT_W       = LAT_W_DEF
) (
    input  logic              Cclk,
    input  logic              Rstn,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_err,
    output logic [LAT_W-1:0]  res_lat,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Req,
    input  logic              Ack,
    input  logic [DATA_W-1:0] Sum,
    output logic [1:0]        fsm_state
);

    state_t           state;
    logic             accept;
    logic             finish_ok;
    logic             finish_tmo;
    logic             expired;
    logic [LAT_W-1:0] lat_next;
    logic [LAT_W-1:0] lat_tmo;

    // A low Ack while idle means the adder is still finishing; hold off.
    assign op_ready  = (state == IDLE) && Ack;
    assign accept    = op_valid && op_ready;
    assign finish_ok = (state == WAIT) && Ack;
    // Timeout only when the state's own exit condition is absent this edge.
    assign finish_tmo = expired &&
                        (((state == ISSUE) && Ack) || ((state == WAIT) && !Ack));
    assign fsm_state = state;

    adder_req_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LAT_W       (LAT_W)
    ) u_timer (
        .Cclk     (Cclk),
        .Rstn     (Rstn),
        .load     (accept),
        .en       ((state == ISSUE) || (state == WAIT)),
        .expired  (expired),
        .lat_next (lat_next),
        .lat_tmo  (lat_tmo)
    );

    // Request FSM: state, Req and the operand registers.
    always_ff @(posedge Cclk) begin
        if (!Rstn) begin
            state <= IDLE;
            Req   <= 1'b0;
            A     <= '0;
            B     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                        A     <= op_a;
                        B     <= op_b;
                        Req   <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Ack low means the adder has taken the request.
                    if (!Ack) begin
                        state <= WAIT;
                        Req   <= 1'b0;
                    end else if (finish_tmo) begin
                        state <= DONE;
                        Req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (finish_ok || finish_tmo) begin
                        state <= DONE;
                        Req   <= 1'b0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Req   <= 1'b0;
                end
            endcase
        end
    end

    // Result registers: loaded on completion or timeout, held until consumed.
    always_ff @(posedge Cclk) begin
        if (!Rstn) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_err   <= 1'b0;
            res_lat   <= '0;
        end else if (finish_ok) begin
            res_valid <= 1'b1;
            res_sum   <= Sum;
            res_err   <= 1'b0;
            res_lat   <= lat_next;
        end else if (finish_tmo) begin
            res_valid <= 1'b1;
            res_sum   <= '0;
            res_err   <= 1'b1;
            res_lat   <= lat_tmo;
        end else if ((state == DONE) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_requester.sv
// tb_adder_requester
//   Directed bench for adder_requester with a behavioural byte-serial adder
//   responder. Expected sums, error flags and latencies are hand-computed
//   constants queued in exp_q and checked when each result appears.
module tb_adder_requester;

    logic        Cclk = 1'b0;
    logic        Rstn;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_sum;
    logic        res_err;
    logic [7:0]  res_lat;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Ack = 1'b1;
    logic [31:0] Sum = 32'h0;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Responder control: 0 = normal adder, 1 = never accepts,
    // 2 = accepts then holds Ack low until release_ack.
    int   mode        = 0;
    logic release_ack = 1'b0;
    int   unstable    = 0;
    int   low_run     = 100;
    int   last_gap    = 100;
    logic req_q       = 1'b0;

    adder_requester dut (
        .Cclk      (Cclk),
        .Rstn      (Rstn),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_err   (res_err),
        .res_lat   (res_lat),
        .A         (A),
        .B         (B),
        .Req       (Req),
        .Ack       (Ack),
        .Sum       (Sum),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 Cclk = ~Cclk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- adder responder model ----------------
    function automatic int nbytes(input logic [31:0] v);
        int n = 1;
        for (int i = 0; i < 4; i++) begin
            if (v[i*8 +: 8] != 8'h0) n = i + 1;
        end
        return n;
    endfunction

    always begin
        logic [31:0] a_cap;
        logic [31:0] b_cap;
        int          n;
        @(posedge Req);
        #1;
        a_cap = A;
        b_cap = B;
        if (mode == 0) begin
            Ack = 1'b0;
            Sum = 32'hDEAD_BEEF;
            n = nbytes(a_cap | b_cap);
            repeat (n) begin
                @(posedge Cclk);
                if (A !== a_cap || B !== b_cap) unstable++;
            end
            #1;
            Sum = a_cap + b_cap;
            Ack = 1'b1;
        end else if (mode == 2) begin
            Ack = 1'b0;
            wait (release_ack);
            Ack = 1'b1;
        end
    end

    // Req low-gap monitor: edges with Req sampled low before each rise.
    always @(posedge Cclk) begin
        if (Req) begin
            if (!req_q) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        req_q <= Req;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_op(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin
            @(posedge Cclk); #1;
            n++;
        end
        if (!op_ready) begin
            check("op_accept_timeout", 32'd0, 32'd1);
            op_valid = 1'b0;
        end else begin
            @(posedge Cclk); #1;
            op_valid = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_err,
                                input logic [31:0] exp_lat, output int cyc);
        logic [31:0] exp_sum;
        cyc = 0;
        while (!res_valid && cyc < 60) begin
            @(posedge Cclk); #1;
            cyc++;
        end
        if (!res_valid) begin
            check({tag, "_result_timeout"}, 32'd0, 32'd1);
        end else begin
            exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
            check({tag, "_sum"}, res_sum, exp_sum);
            check({tag, "_err"}, {31'd0, res_err}, exp_err);
            check({tag, "_lat"}, {24'd0, res_lat}, exp_lat);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int bp_bad;
        Rstn      = 1'b0;
        op_valid  = 1'b0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        res_ready = 1'b1;
        repeat (3) @(posedge Cclk);
        #1;
        check("rst_req",       {31'd0, Req},       32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_sum",   res_sum,            32'd0);
        check("rst_res_err",   {31'd0, res_err},   32'd0);
        check("rst_res_lat",   {24'd0, res_lat},   32'd0);
        check("rst_a",         A,                  32'd0);
        check("rst_b",         B,                  32'd0);
        check("rst_state",     {30'd0, fsm_state}, 32'd0);
        check("rst_op_ready",  {31'd0, op_ready},  32'd1);
        Rstn = 1'b1;
        @(posedge Cclk); #1;

        // 1) single-byte operands
        exp_q.push_back(32'h0000_000C);
        send_op(32'h05, 32'h07);
        check("t1_req_high", {31'd0, Req}, 32'd1);
        check("t1_a", A, 32'h05);
        check_result("t1", 32'd0, 32'd3, cyc);
        @(posedge Cclk); #1;
        check("t1_valid_drop", {31'd0, res_valid}, 32'd0);

        // 2) four-byte operands, operand stability
        exp_q.push_back(32'h2345_6789);
        send_op(32'h1234_5678, 32'h1111_1111);
        check_result("t2", 32'd0, 32'd6, cyc);
        check("t2_ab_stable", unstable, 32'd0);
        check("t2_a_hold", A, 32'h1234_5678);
        check("t2_b_hold", B, 32'h1111_1111);

        // 3) carry out of bit 31 is dropped
        exp_q.push_back(32'h0000_0000);
        send_op(32'hFFFF_FFFF, 32'h0000_0001);
        check_result("t3", 32'd0, 32'd6, cyc);

        // two- and three-byte operands
        exp_q.push_back(32'h0000_1235);
        send_op(32'h0000_1234, 32'h0000_0001);
        check_result("t3b", 32'd0, 32'd4, cyc);
        exp_q.push_back(32'h00AB_0000);
        send_op(32'h00AB_0000, 32'h0000_0000);
        check_result("t3c", 32'd0, 32'd5, cyc);

        // 4) result back-pressure, then a second op
        @(posedge Cclk); #1;
        res_ready = 1'b0;
        exp_q.push_back(32'h0000_0003);
        send_op(32'h01, 32'h02);
        check_result("t4", 32'd0, 32'd3, cyc);
        bp_bad   = 0;
        op_a     = 32'h0A;
        op_b     = 32'h14;
        op_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Cclk); #1;
            if (!res_valid || res_sum !== 32'h3 || res_lat !== 8'd3 || op_ready || Req)
                bp_bad++;
        end
        check("t4_bp_hold", bp_bad, 32'd0);
        op_valid  = 1'b0;
        res_ready = 1'b1;
        exp_q.push_back(32'h0000_001E);
        send_op(32'h0A, 32'h14);
        check_result("t4b", 32'd0, 32'd3, cyc);
        check("t4_req_gap_ok", (last_gap >= 2) ? 32'd1 : 32'd0, 32'd1);

        // 5a) adder never accepts
        @(posedge Cclk); #1;
        mode = 1;
        exp_q.push_back(32'h0);
        send_op(32'h55, 32'h66);
        check_result("t5a", 32'd1, 32'd16, cyc);
        check("t5a_edges", cyc, 32'd16);
        check("t5a_req_low", {31'd0, Req}, 32'd0);

        // 5b) adder accepts, Ack stuck low
        @(posedge Cclk); #1;
        mode = 2;
        exp_q.push_back(32'h0);
        send_op(32'h77, 32'h88);
        check_result("t5b", 32'd1, 32'd16, cyc);
        check("t5b_req_low", {31'd0, Req}, 32'd0);
        @(posedge Cclk); #1;
        check("t5b_blocked_by_ack", {31'd0, op_ready}, 32'd0);
        release_ack = 1'b1;
        #1;
        release_ack = 1'b0;
        check("t5b_ready_after_ack", {31'd0, op_ready}, 32'd1);

        // 6) reset while waiting for completion
        send_op(32'h10, 32'h20);
        @(posedge Cclk); #1;
        check("t6_in_wait", {30'd0, fsm_state}, 32'd2);
        Rstn = 1'b0;
        @(posedge Cclk); #1;
        check("t6_rst_req",       {31'd0, Req},       32'd0);
        check("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("t6_rst_op_ready",  {31'd0, op_ready},  32'd0);
        check("t6_rst_state",     {30'd0, fsm_state}, 32'd0);
        Rstn        = 1'b1;
        release_ack = 1'b1;
        #1;
        release_ack = 1'b0;
        mode        = 0;
        check("t6_op_ready_ack", {31'd0, op_ready}, 32'd1);
        exp_q.push_back(32'h0000_0044);
        send_op(32'h40, 32'h04);
        check_result("t6", 32'd0, 32'd3, cyc);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
